led_fade_pwm: RTL
=================

# led_fade_pwm

Downstream stage of the 4-LED chaser: consumes the chaser's one-hot `led_c` pattern and drives the board LEDs through per-channel PWM with a decaying brightness trail. A lit input channel jumps to full brightness. Once its input drops, the channel fades linearly to off, producing a "comet tail" behind the running light. Everything runs in the chaser's clock domain; no synchronizers are needed.

## Interface
- `PWM_BITS`, 8: width of the brightness level and the PWM counter; full scale is `2^PWM_BITS-1`.
- `FADE_DIV`, 50000: clocks per fade tick (≥2).
- `FADE_STEP`, 8: amount subtracted from each fading level per tick (1..2^PWM_BITS-1).
- `clk`, in, 1: system clock; the only clock.
- `rstn`, in, 1: asynchronous, active-low reset.
- `led_in`, in, 4: LED pattern from the chaser, same clock domain; any bit combination is legal.
- `led_out`, out, 4: PWM-modulated LED drive, registered.

## Operation
- State: `pwm_cnt` [PWM_BITS], `div_cnt` (width ≥ clog2(FADE_DIV)), `level[0..3]` [PWM_BITS] each, `led_out` [4].
- Reset (asynchronous, `rstn`=0): all state, including `led_out`, is 0 immediately, independent of `clk`.
- Prescaler:
  - `div_cnt` counts 0..FADE_DIV-1, then wraps to 0.
  - `fade_tick` is a 1-cycle internal pulse, true while `div_cnt`==FADE_DIV-1.
- PWM counter:
  - `pwm_cnt` counts 0..MAX-1, where MAX=2^PWM_BITS-1, then wraps to 0. Period is MAX clocks (255 at default).
  - Free-running; never reset except by `rstn`.
- Per channel i, evaluated in priority order each clock:
  1. `led_in[i]`=1: `level[i]` <= MAX. Load wins over a simultaneous `fade_tick`.
  2. Else, on `fade_tick`: `level[i]` <= `level[i]`-FADE_STEP if `level[i]`≥FADE_STEP, otherwise 0. The level saturates at 0 and never wraps.
  3. Else: hold.
- Output: `led_out[i]` <= (`pwm_cnt` < `level[i]`), an unsigned compare.
  - Level MAX gives a constantly-on output, because `pwm_cnt` never reaches MAX.
  - Level 0 gives a constantly-off output.
  - Level L gives exactly L high cycles per PWM period.
- Channels are independent. They share `pwm_cnt` and `fade_tick`.
- Full fade from MAX to 0 takes ceil(MAX/FADE_STEP) ticks: 32 ticks, 1.6 M clocks at default.

## Timing
- `led_in[i]` high at edge N: `level[i]`=MAX after edge N, and `led_out[i]`=1 after edge N+1 (2-clock latency).
- While `led_in[i]` stays high, the level is re-loaded every cycle and never decays.
- `led_in[i]` falls: the first decrement occurs at the next `fade_tick` edge. The phase is set by the free-running `div_cnt`, so the first tick may arrive anywhere from 1 to FADE_DIV clocks later.
- `led_out` follows `level` changes one clock later. Duty-cycle changes may take effect mid PWM period; glitch-free period alignment is not required.
- `rstn` deasserted: counting resumes on the first `clk` edge that sees `rstn`=1. The first `fade_tick` comes FADE_DIV clocks after that edge, and the first `pwm_cnt` wrap comes MAX clocks after it.
- Reset mid-fade: levels return to 0 with no residual trail.

## Test plan
Run with `PWM_BITS`=4 (MAX=15), `FADE_DIV`=4, `FADE_STEP`=4 unless noted.
- Reset: hold `rstn`=0 with random `led_in` and clock running → `led_out`=0000 throughout. Assert `rstn`=0 asynchronously between edges → `led_out` clears before the next edge.
- Full on: `led_in`=0001 held 100 clocks → `led_out[0]`=1 from the 2nd clock onward and never drops; the other bits stay 0.
- Fade: `led_in`=0001 for 10 clocks, then 0000 → `level[0]` steps through 15, 11, 7, 3, 0 on successive ticks, 4 clocks apart. Measured high cycles per 15-clock period are 15, 11, 7, 3, 0 once each level has held a full period (use `FADE_DIV`=30 for the measurement).
- Saturation: `FADE_STEP`=6 from level 15 → 9, 3, 0, and the level stays 0; it never wraps to a large value.
- Priority: drive `led_in[2]` high exactly on a `fade_tick` cycle while the level is 7 → the level becomes 15, not 3.
- Chaser pattern: `led_in` cycles 0001, 0010, 0100, 1000 every 8 clocks → at each hand-off the new channel is at 15 and the previous channel decays. Check bit-exact against a reference model over 2000 clocks.

Source files
------------

// File: rtl/led_fade_pwm_if.sv
// LED bus between the chaser and the fade/PWM output stage.
// The chaser side (master) drives the one-hot pattern.
// The output stage (slave) returns the PWM-modulated LED drive.
interface led_fade_pwm_if;
    logic [3:0] led_in;
    logic [3:0] led_out;

    modport master (
        output led_in,
        input  led_out
    );

    modport slave (
        input  led_in,
        output led_out
    );
endinterface

// File: rtl/led_fade_pwm.sv
// Per-channel PWM LED driver with a linear "comet tail" fade.
// A lit input channel snaps to full brightness. Once released, the
// channel decays by FADE_STEP on every fade tick until it reaches zero.
// All four channels share one free-running PWM counter and one fade
// prescaler.
module led_fade_pwm #(
    parameter int PWM_BITS  = 8,
    parameter int FADE_DIV  = 50000,
    parameter int FADE_STEP = 8
) (
    input  logic          clk,
    input  logic          rstn,
    led_fade_pwm_if.slave ledIf
);

    localparam int                  DIV_W    = $clog2(FADE_DIV);
    localparam logic [PWM_BITS-1:0] MAX_LVL  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_LAST = MAX_LVL - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(FADE_STEP);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);

    logic [DIV_W-1:0]    divCnt_q, divCnt_d;
    logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
    logic [PWM_BITS-1:0] level_q [4];
    logic [PWM_BITS-1:0] level_d [4];
    logic [3:0]          ledOut_q, ledOut_d;
    logic                fadeTick;

    // One-cycle fade pulse on the last count of the prescaler.
    assign fadeTick = (divCnt_q == DIV_LAST);

    // Prescaler wraps after FADE_DIV clocks; PWM counter wraps after MAX clocks, so MAX itself is never reached.
    always_comb begin
        divCnt_d = divCnt_q + DIV_W'(1);
        pwmCnt_d = pwmCnt_q + PWM_BITS'(1);
        if (fadeTick) begin
            divCnt_d = '0;
        end
        if (pwmCnt_q == PWM_LAST) begin
            pwmCnt_d = '0;
        end
    end

    // Brightness update: load beats fade, fade saturates at zero; output compares the current level against the PWM count.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            level_d[i] = level_q[i];
            if (ledIf.led_in[i]) begin
                level_d[i] = MAX_LVL;
            end else if (fadeTick) begin
                if (level_q[i] >= STEP) begin
                    level_d[i] = level_q[i] - STEP;
                end else begin
                    level_d[i] = '0;
                end
            end
            ledOut_d[i] = (pwmCnt_q < level_q[i]);
        end
    end

    // State registers; an asynchronous reset clears every level so no trail survives a reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            divCnt_q <= '0;
            pwmCnt_q <= '0;
            ledOut_q <= '0;
            for (int i = 0; i < 4; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            divCnt_q <= divCnt_d;
            pwmCnt_q <= pwmCnt_d;
            ledOut_q <= ledOut_d;
            for (int i = 0; i < 4; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign ledIf.led_out = ledOut_q;

endmodule
